// File: rtl/div2_engine_if.sv
// rtl/div2_engine_if.sv - Start/Ack handshake and byte-wide data-memory port of div2_engine
interface div2_engine_if #(
  parameter int AW = 8
);
  logic          Start;
  logic          Ack;
  logic [AW-1:0] MemAddr;
  logic [7:0]    MemRdData;
  logic [7:0]    MemWrData;
  logic          MemWrEn;

  modport master (
    input  Start, MemRdData,
    output Ack, MemAddr, MemWrData, MemWrEn
  );

  modport slave (
    output Start, MemRdData,
    input  Ack, MemAddr, MemWrData, MemWrEn
  );
endinterface

// File: rtl/div2_engine.sv
// rtl/div2_engine.sv - 16/8 fixed-point divider engine over byte memory; DIV2_ROUND_EN adds half-LSB rounding
module div2_engine #(
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 4,
  parameter int AW       = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  div2_engine_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ARMED, RD0, RD1, RD2, DIV, WR0, WR1, WR2, DONE
  } state_t;

`ifdef DIV2_ROUND_EN
  localparam logic [4:0] DIV_LAST = 5'd24;
`else
  localparam logic [4:0] DIV_LAST = 5'd23;
`endif

  state_t        state, state_next;
  logic [15:0]   dividend;
  logic [7:0]    divisor;
  logic [7:0]    rem, rem_next;
  logic [23:0]   q, q_next;
  logic [4:0]    count;
  logic          in_bit, ge, busy;
  logic [8:0]    r_shift;
  logic          ack_d, wr_en_d;
  logic [AW-1:0] addr_d;
  logic [7:0]    data_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= IDLE;
      bus.Ack       <= 1'b0;
      bus.MemWrEn   <= 1'b0;
      bus.MemAddr   <= '0;
      bus.MemWrData <= '0;
    end else begin
      state         <= state_next;
      bus.Ack       <= ack_d;
      bus.MemWrEn   <= wr_en_d;
      bus.MemAddr   <= addr_d;
      bus.MemWrData <= data_d;
    end
  end

  assign busy = (state == RD0) || (state == RD1) || (state == RD2) || (state == DIV) ||
                (state == WR0) || (state == WR1) || (state == WR2);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = ARMED;
      ARMED:   if (!bus.Start) state_next = RD0;
      RD0:     state_next = RD1;
      RD1:     state_next = RD2;
      RD2:     state_next = (bus.MemRdData == 8'h00) ? WR0 : DIV;
      DIV:     if (count == DIV_LAST) state_next = WR0;
      WR0:     state_next = WR1;
      WR1:     state_next = WR2;
      WR2:     state_next = DONE;
      DONE:    if (bus.Start) state_next = ARMED;
      default: state_next = IDLE;
    endcase
    if (busy && bus.Start) state_next = ARMED;
  end

  // Quotient bits shift into q from the bottom as numerator bits leave the top.
`ifdef DIV2_ROUND_EN
  assign in_bit = (count == DIV_LAST) ? 1'b0 : q[23];
`else
  assign in_bit = q[23];
`endif
  assign r_shift  = {rem, in_bit};
  assign ge       = (r_shift >= {1'b0, divisor});
  assign rem_next = ge ? 8'(r_shift - {1'b0, divisor}) : r_shift[7:0];

  always_comb begin
    q_next = q;
    case (state)
      RD2: q_next = (bus.MemRdData == 8'h00) ? 24'hFFFFFF : {dividend, 8'h00};
      DIV: begin
`ifdef DIV2_ROUND_EN
        // The extra cycle yields the guard bit, added into the finished quotient.
        if (count == DIV_LAST) q_next = q + {23'd0, ge};
        else                   q_next = {q[22:0], ge};
`else
        q_next = {q[22:0], ge};
`endif
      end
      default: q_next = q;
    endcase
  end

  always_comb begin
    ack_d   = (state_next == DONE);
    wr_en_d = (state_next == WR0) || (state_next == WR1) || (state_next == WR2);
    addr_d  = bus.MemAddr;
    data_d  = bus.MemWrData;
    case (state_next)
      RD0: addr_d = AW'(IN_BASE);
      RD1: addr_d = AW'(IN_BASE + 1);
      RD2: addr_d = AW'(IN_BASE + 2);
      WR0: begin addr_d = AW'(OUT_BASE);     data_d = q_next[23:16]; end
      WR1: begin addr_d = AW'(OUT_BASE + 1); data_d = q_next[15:8];  end
      WR2: begin addr_d = AW'(OUT_BASE + 2); data_d = q_next[7:0];   end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      q        <= '0;
      count    <= '0;
    end else begin
      case (state)
        RD0: dividend[15:8] <= bus.MemRdData;
        RD1: dividend[7:0]  <= bus.MemRdData;
        RD2: begin
          divisor <= bus.MemRdData;
          rem     <= '0;
          count   <= '0;
          q       <= q_next;
        end
        DIV: begin
          rem   <= rem_next;
          q     <= q_next;
          count <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div2_engine.sv
// tb/tb_div2_engine.sv - directed vector bench for div2_engine with memory model
module tb_div2_engine;

`ifdef DIV2_ROUND_EN
  localparam int LAT = 31;
  localparam logic [23:0] Q_2_3 = 24'h0000AB;
`else
  localparam int LAT = 30;
  localparam logic [23:0] Q_2_3 = 24'h0000AA;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div2_engine_if #(.AW(8)) bus ();

  div2_engine #(.IN_BASE(0), .OUT_BASE(4), .AW(8)) dut (
    .Clk   (clk),
    .Reset (resetn),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr, ld_data;
  int         wr_total = 0;

  assign bus.MemRdData = mem[bus.MemAddr];

  always @(posedge clk) begin
    if (bus.MemWrEn)  mem[bus.MemAddr] <= bus.MemWrData;
    else if (ld_en)   mem[ld_addr] <= ld_data;
  end

  always @(posedge clk) if (bus.MemWrEn) wr_total <= wr_total + 1;

  typedef struct {
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [23:0] q;
    int          lat;
  } vec_t;

  vec_t vecs [5];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic load_operands(input logic [15:0] dvd, input logic [7:0] dvs);
    poke(8'd0, dvd[15:8]);
    poke(8'd1, dvd[7:0]);
    poke(8'd2, dvs);
  endtask

  task automatic preset_out(input logic [7:0] d);
    poke(8'd4, d);
    poke(8'd5, d);
    poke(8'd6, d);
  endtask

  function automatic logic [23:0] result();
    return {mem[4], mem[5], mem[6]};
  endfunction

  // Counts edges after the Start=0 sampling edge until Ack is seen; -1 if never.
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.Ack) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk);
  endtask

  int lat, w0;
  logic ack_seen;

  initial begin
    vecs[0] = '{16'h3200, 8'h19, 24'h020000, LAT};
    vecs[1] = '{16'h0300, 8'hFF, 24'h000303, LAT};
    vecs[2] = '{16'hFFFF, 8'h01, 24'hFFFF00, LAT};
    vecs[3] = '{16'h0002, 8'h03, Q_2_3,      LAT};
    vecs[4] = '{16'h1234, 8'h00, 24'hFFFFFF, 6};

    resetn    = 1'b0;
    bus.Start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ack",    {31'd0, bus.Ack},     32'd0);
    check("reset_wren",   {31'd0, bus.MemWrEn}, 32'd0);
    check("reset_addr",   {24'd0, bus.MemAddr}, 32'd0);
    check("reset_wrdata", {24'd0, bus.MemWrData}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      load_operands(vecs[v].dividend, vecs[v].divisor);
      preset_out(8'h00);
      w0 = wr_total;
      start_pulse();
      wait_ack(lat);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("vec%0d_result", v), {8'd0, result()}, {8'd0, vecs[v].q});
      check($sformatf("vec%0d_writes", v), wr_total - w0, 32'd3);
    end

    // Abort partway through the division.
    load_operands(16'h3200, 8'h19);
    preset_out(8'h5A);
    w0 = wr_total;
    start_pulse();
    repeat (13) @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      ack_seen |= bus.Ack;
    end
    check("abort_ack",    {31'd0, ack_seen}, 32'd0);
    check("abort_writes", wr_total - w0, 32'd0);
    check("abort_mem",    {8'd0, result()}, 32'h005A5A5A);
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk);
    wait_ack(lat);
    check("relaunch_latency", lat, LAT);
    check("relaunch_result",  {8'd0, result()}, 32'h00020000);

    // Reset asserted while dividing.
    preset_out(8'h11);
    w0 = wr_total;
    start_pulse();
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_ack",    {31'd0, bus.Ack},       32'd0);
    check("midreset_wren",   {31'd0, bus.MemWrEn},   32'd0);
    check("midreset_addr",   {24'd0, bus.MemAddr},   32'd0);
    check("midreset_wrdata", {24'd0, bus.MemWrData}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("midreset_mem",    {8'd0, result()}, 32'h00111111);
    check("midreset_writes", wr_total - w0, 32'd0);

    load_operands(16'h0002, 8'h03);
    start_pulse();
    wait_ack(lat);
    check("fresh_latency", lat, LAT);
    check("fresh_result",  {8'd0, result()}, {8'd0, Q_2_3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
